uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter Databits, default 8: width of one UART character; SHALL match the downstream transmitter setting.
REQ-002 Parameter Ports, default 4, legal range 2..16: number of requester streams.
REQ-003 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port s_axis_tdata, input, Ports*Databits: requester data; requester i occupies bits [i*Databits +: Databits].
REQ-006 Port s_axis_tvalid, input, Ports: per-requester valid.
REQ-007 Port s_axis_tlast, input, Ports: per-requester end-of-packet marker.
REQ-008 Port s_axis_tready, output, Ports: per-requester ready.
REQ-009 Port m_axis_tdata, output, Databits: character to the UART transmitter.
REQ-010 Port m_axis_tvalid, output, 1: character valid.
REQ-011 Port m_axis_tready, input, 1: transmitter ready.
REQ-012 Port grant, output, $clog2(Ports): index of the current owner; value of the last owner while idle.
REQ-013 Port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 The state machine SHALL have states IDLE, HDR and DATA; HDR is reachable only with UART_ARB_ID_TAG_EN.
REQ-015 In IDLE with any s_axis_tvalid high, the block SHALL register a round-robin winner: the first valid index searched upward from grant+1, wrapping modulo Ports.
REQ-016 On that same edge it SHALL move to HDR if tagging is enabled, otherwise to DATA; arbitration latency is 1 cycle.
REQ-017 In IDLE, m_axis_tvalid SHALL be 0 and all s_axis_tready bits SHALL be 0.
REQ-018 In DATA: m_axis_tdata and m_axis_tvalid SHALL be driven combinationally from the granted requester, s_axis_tready[grant] SHALL equal m_axis_tready, and all other ready bits SHALL be 0.
REQ-019 The grant SHALL be held (packet lock) until a handshake with s_axis_tlast[grant]=1; the FSM then SHALL return to IDLE.
REQ-020 Back-to-back packets SHALL incur exactly one IDLE cycle between the last character of one packet and the first character (or header) of the next.
REQ-021 Requests from non-granted ports during a packet SHALL be ignored; they SHALL not alter grant or pointer state.
REQ-022 If the granted requester deasserts tvalid mid-packet, the block SHALL stay in DATA with m_axis_tvalid=0; it SHALL have no timeout.
REQ-023 If only the previous owner requests, it SHALL win again (wrap-around search includes itself last).
REQ-024 A single-character packet (tlast on the first beat) SHALL be legal.

Reset
REQ-025 While rst is low: state=IDLE, grant=Ports-1 (so port 0 wins first), busy=0, m_axis_tvalid=0, all s_axis_tready=0.
REQ-026 Reset asserted mid-packet SHALL abort the packet immediately, with no further handshakes; the partial packet SHALL not be resumed.

Configuration
REQ-027 Macro UART_ARB_ID_TAG_EN: when defined, each granted packet SHALL be preceded by one header character in HDR.
REQ-028 The header character SHALL be {zeros, grant} zero-extended to Databits, with m_axis_tvalid=1 and all s_axis_tready=0.
REQ-029 The header character SHALL advance the FSM to DATA on the m_axis_tready handshake.
REQ-030 When UART_ARB_ID_TAG_EN is undefined, no HDR logic SHALL be synthesised and packets SHALL pass untagged.

Structure
REQ-031 A shared package uart_pkg SHALL hold the FSM state encoding (IDLE=2'd0, HDR=2'd1, DATA=2'd2) and a function computing the grant width from Ports.
REQ-032 The round-robin search SHALL live in one sub-module, uart_rr_pick (inputs: request vector, last grant; outputs: winner index, any_req). The remaining logic SHALL stay in uart_tx_arbiter.

Verification
REQ-033 After reset, ports 0 and 2 both request 1-character packets 0x41 and 0x42 -> output 0x41 (grant=0), then 0x42 (grant=2), with one IDLE cycle between them.
REQ-034 Port 1 sends 3-character packet 0x10,0x11,0x12 while port 3 requests from cycle 1 -> all three port-1 characters are output contiguously before any port-3 data.
REQ-035 m_axis_tready held low for 5 cycles mid-packet -> tdata is stable, no requester handshake occurs, and the packet completes intact afterwards.
REQ-036 All 4 ports request continuously with single-character packets -> grant sequence 0,1,2,3,0,1.
REQ-037 rst pulsed low during character 2 of a 4-character packet -> m_axis_tvalid=0 the same cycle, busy=0, and the next grant is 0.
REQ-038 With UART_ARB_ID_TAG_EN defined, port 2 sends 0xAA -> output sequence 0x02, 0xAA.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the grant-width helper used by the top and the round-robin picker.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    // Width of an index that can name any of `ports` requesters.
    function automatic int grant_width(input int ports);
        return (ports > 1) ? $clog2(ports) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin winner search: first requesting index above `last`, wrapping,
// with `last` itself considered at the very end.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int Ports = 4,
    parameter int Gw    = grant_width(Ports)
) (
    input  logic [Ports-1:0] req,
    input  logic [Gw-1:0]    last,
    output logic [Gw-1:0]    winner,
    output logic             any_req
);

    // One spare bit so last + Ports cannot overflow before the wrap.
    logic [Gw:0] idx;

    assign any_req = |req;

    // Scan from the farthest candidate down to the nearest; the nearest
    // requesting index is written last and therefore wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        idx    = '0;
        winner = last;
        for (int i = Ports; i >= 1; i--) begin
            idx = {1'b0, last} + (Gw + 1)'(i);
            if (idx >= (Gw + 1)'(Ports)) begin
                idx = idx - (Gw + 1)'(Ports);
            end
            if (req[idx[Gw-1:0]]) begin
                winner = idx[Gw-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter merging several character streams into
// one UART transmitter. Define UART_ARB_ID_TAG_EN to prefix every packet
// with a header character carrying the owner's index.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int Databits = 8,
    parameter int Ports    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [Ports*Databits-1:0]     s_axis_tdata,
    input  logic [Ports-1:0]              s_axis_tvalid,
    input  logic [Ports-1:0]              s_axis_tlast,
    output logic [Ports-1:0]              s_axis_tready,
    output logic [Databits-1:0]           m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [grant_width(Ports)-1:0] grant,
    output logic                          busy
);

    localparam int Gw = grant_width(Ports);

    state_t        state, state_next;
    logic [Gw-1:0] grant_next;
    logic [Gw-1:0] winner;
    logic          any_req;

    uart_rr_pick #(
        .Ports (Ports),
        .Gw    (Gw)
    ) u_pick (
        .req     (s_axis_tvalid),
        .last    (grant),
        .winner  (winner),
        .any_req (any_req)
    );

    // Reset parks the pointer on the top index so port 0 is searched first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            grant <= Gw'(Ports - 1);
        end else begin
            // NOTE: non-blocking assignments let every flop sample the
            // pre-edge values, so register order never matters.
            state <= state_next;
            grant <= grant_next;
        end
    end

    always_comb begin
        state_next    = state;
        grant_next    = grant;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        s_axis_tready = '0;

        case (state)
            IDLE: begin
                if (any_req) begin
                    grant_next = winner;
`ifdef UART_ARB_ID_TAG_EN
                    state_next = HDR;
`else
                    state_next = DATA;
`endif
                end
            end

`ifdef UART_ARB_ID_TAG_EN
            HDR: begin
                m_axis_tdata  = Databits'(grant);
                m_axis_tvalid = 1'b1;
                if (m_axis_tready) begin
                    state_next = DATA;
                end
            end
`endif

            DATA: begin
                m_axis_tdata         = s_axis_tdata[int'(grant)*Databits +: Databits];
                m_axis_tvalid        = s_axis_tvalid[grant];
                s_axis_tready[grant] = m_axis_tready;
                // Ownership ends only on the handshake of the owner's last beat.
                if (s_axis_tvalid[grant] && m_axis_tready && s_axis_tlast[grant]) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle comparison against a
// queue-based packet model plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

    localparam int DB = 8;
    localparam int P  = 4;
    localparam int GW = 2;
`ifdef UART_ARB_ID_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [P*DB-1:0] s_axis_tdata;
    logic [P-1:0]    s_axis_tvalid;
    logic [P-1:0]    s_axis_tlast;
    logic [P-1:0]    s_axis_tready;
    logic [DB-1:0]   m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [GW-1:0]   grant;
    logic            busy;

    uart_tx_arbiter #(.Databits(DB), .Ports(P)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant         (grant),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sources: per-port queues of {last, data}; per-port valid probability.
    logic [DB:0] src_q[P][$];
    int          vprob[P];
    int          rdy_mode;  // 0 random, 1 always ready, 2 stalled

    // Model: owning port (-1 when idle), last owner, header still owed.
    int own    = -1;
    int last_g = P - 1;
    bit hdr_pend;
    int cyc;

    typedef struct {
        int port;
        int data;
        bit beat;
        int cyc;
    } ent_t;
    ent_t dut_log[$];

    function automatic void drop_packet(input int p);
        logic [DB:0] h;
        bit done = 1'b0;
        while (!done && src_q[p].size() > 0) begin
            h = src_q[p].pop_front();
            done = h[DB];
        end
    endfunction

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < P; i++) if (src_q[i].size() > 0) e = 1'b0;
        return e;
    endfunction

    always @(negedge clk) begin : cmp
        logic          ev;
        logic [DB-1:0] ed;
        logic [P-1:0]  er;
        logic          eb;
        int            eg;
        logic [DB:0]   h;
        cyc++;
        if (m_axis_tvalid && m_axis_tready)
            dut_log.push_back('{port: int'(grant), data: int'(m_axis_tdata),
                                beat: |(s_axis_tvalid & s_axis_tready), cyc: cyc});
        ev = 1'b0; ed = '0; er = '0; eb = 1'b0; eg = last_g;
        if (!rst) begin
            if (own >= 0) drop_packet(own);
            own = -1; last_g = P - 1; hdr_pend = 1'b0; eg = P - 1;
        end else if (own < 0) begin
            for (int i = 1; i <= P; i++)
                if (own < 0 && s_axis_tvalid[(last_g + i) % P]) own = (last_g + i) % P;
            if (own >= 0) begin
                last_g = own; hdr_pend = TAG;
            end
        end else begin
            eb = 1'b1; eg = own;
            if (hdr_pend) begin
                ev = 1'b1; ed = DB'(own);
                if (m_axis_tready) hdr_pend = 1'b0;
            end else begin
                ev = s_axis_tvalid[own];
                er[own] = m_axis_tready;
                if (src_q[own].size() > 0) ed = src_q[own][0][DB-1:0];
                if (ev && m_axis_tready && src_q[own].size() > 0) begin
                    h = src_q[own].pop_front();
                    if (h[DB]) own = -1;
                end
            end
        end
        check("m_tvalid", 32'(m_axis_tvalid), 32'(ev));
        if (ev) check("m_tdata", 32'(m_axis_tdata), 32'(ed));
        check("s_tready", 32'(s_axis_tready), 32'(er));
        check("busy", 32'(busy), 32'(eb));
        check("grant", 32'(grant), 32'(eg));
    end

    task automatic drive();
        for (int i = 0; i < P; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(99) < vprob[i]) begin
                s_axis_tvalid[i]          = 1'b1;
                s_axis_tdata[i*DB +: DB]  = src_q[i][0][DB-1:0];
                s_axis_tlast[i]           = src_q[i][0][DB];
            end else begin
                s_axis_tvalid[i]          = 1'b0;
                s_axis_tdata[i*DB +: DB]  = DB'($urandom);
                s_axis_tlast[i]           = 1'($urandom);
            end
        end
        case (rdy_mode)
            0:       m_axis_tready = ($urandom_range(99) < 70);
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'b0;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_s_tready", 32'(s_axis_tready), 32'h0);
        check("rst_grant", 32'(grant), 32'h3);
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (!(all_empty() && own < 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(all_empty() && own < 0), 32'h1);
        step();
    endtask

    // Index into dut_log of the k-th data beat at or after log position base.
    function automatic int beat_idx(input int base, input int k);
        int seen = 0;
        for (int i = base; i < dut_log.size(); i++) begin
            if (dut_log[i].beat) begin
                if (seen == k) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    task automatic wait_beat(input int base, input int k, input int budget);
        int n = 0;
        while (beat_idx(base, k) < 0 && n < budget) begin
            step();
            n++;
        end
        check("beat_timeout", 32'(beat_idx(base, k) >= 0), 32'h1);
    endtask

    task automatic expect_beat(input string name, input int base, input int k,
                               input int port, input int data);
        int idx = beat_idx(base, k);
        if (idx < 0) begin
            check(name, 32'hFFFF_FFFF, 32'(data));
        end else begin
            check({name, "_port"}, 32'(dut_log[idx].port), 32'(port));
            check({name, "_data"}, 32'(dut_log[idx].data), 32'(data));
        end
    endtask

    function automatic int beat_cyc(input int base, input int k);
        int idx = beat_idx(base, k);
        return (idx < 0) ? -1000 : dut_log[idx].cyc;
    endfunction

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        rst = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        m_axis_tready = 1'b0;
        rdy_mode = 1;
        for (int i = 0; i < P; i++) vprob[i] = 100;
        #2;
        do_reset();

        // Ports 0 and 2 each send one character; one idle cycle between them.
        base = dut_log.size();
        src_q[0].push_back({1'b1, 8'h41});
        src_q[2].push_back({1'b1, 8'h42});
        wait_drain(50);
        expect_beat("a_first", base, 0, 0, 'h41);
        expect_beat("a_second", base, 1, 2, 'h42);
        check("a_gap", 32'(beat_cyc(base, 1) - beat_cyc(base, 0)), TAG ? 32'd3 : 32'd2);

        // Port 1 packet stays contiguous while port 3 waits.
        do_reset();
        base = dut_log.size();
        src_q[1].push_back({1'b0, 8'h10});
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b1, 8'h12});
        step();
        src_q[3].push_back({1'b1, 8'h30});
        wait_drain(50);
        expect_beat("b0", base, 0, 1, 'h10);
        expect_beat("b1", base, 1, 1, 'h11);
        expect_beat("b2", base, 2, 1, 'h12);
        expect_beat("b3", base, 3, 3, 'h30);
        check("b_contig", 32'(beat_cyc(base, 2) - beat_cyc(base, 0)), 32'd2);

        // Transmitter stalls for 5 cycles mid-packet.
        base = dut_log.size();
        src_q[0].push_back({1'b0, 8'h50});
        src_q[0].push_back({1'b0, 8'h51});
        src_q[0].push_back({1'b0, 8'h52});
        src_q[0].push_back({1'b1, 8'h53});
        wait_beat(base, 1, 50);
        rdy_mode = 2;
        m_axis_tready = 1'b0;
        repeat (5) begin
            #1;
            check("c_stall_data", 32'(m_axis_tdata), 32'h52);
            check("c_stall_ready", 32'(s_axis_tready), 32'h0);
            step();
        end
        rdy_mode = 1;
        wait_drain(50);
        for (int k = 0; k < 4; k++) expect_beat("c_beat", base, k, 0, 'h50 + k);
        check("c_count", 32'(beat_idx(base, 4)), 32'hFFFF_FFFF);

        // All ports request continuously with single-character packets.
        do_reset();
        base = dut_log.size();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < P; i++) src_q[i].push_back({1'b1, 8'(8'h60 + i)});
        wait_drain(100);
        for (int k = 0; k < 6; k++) expect_beat("d_rr", base, k, k % P, 'h60 + (k % P));

        // Reset during character 2 of a 4-character packet.
        do_reset();
        base = dut_log.size();
        src_q[0].push_back({1'b0, 8'h70});
        src_q[0].push_back({1'b0, 8'h71});
        src_q[0].push_back({1'b0, 8'h72});
        src_q[0].push_back({1'b1, 8'h73});
        wait_beat(base, 0, 50);
        do_reset();
        src_q[0].push_back({1'b1, 8'h90});
        src_q[1].push_back({1'b1, 8'h91});
        wait_drain(50);
        expect_beat("e_before", base, 0, 0, 'h70);
        expect_beat("e_after0", base, 1, 0, 'h90);
        expect_beat("e_after1", base, 2, 1, 'h91);
        check("e_count", 32'(beat_idx(base, 3)), 32'hFFFF_FFFF);

        // Port 2 sends 0xAA; tagged builds emit the 0x02 header first.
        do_reset();
        base = dut_log.size();
        src_q[2].push_back({1'b1, 8'hAA});
        wait_drain(50);
        check("f_first", (dut_log.size() > base) ? 32'(dut_log[base].data) : 32'hFFFF_FFFF,
              TAG ? 32'h02 : 32'hAA);
        check("f_entries", 32'(dut_log.size() - base), TAG ? 32'd2 : 32'd1);

        // Randomized traffic, with one reset mid-stream.
        rdy_mode = 0;
        for (int i = 0; i < P; i++) begin
            vprob[i] = $urandom_range(100, 20);
            for (int n = $urandom_range(5, 1); n > 0; n--) begin
                int len = $urandom_range(4, 1);
                for (int b = 0; b < len; b++) src_q[i].push_back({1'(b == len - 1), 8'($urandom)});
            end
        end
        repeat (60) step();
        do_reset();
        wait_drain(20000);
        check("g_drained", 32'(all_empty()), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
